// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, waits MEM_LAT cycles for instruction memory,
// latches IR and computes the next PC. `IF_PERF_CNT_EN adds fetch_count.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_LAT  = 1,
   parameter logic [5:0]  HALT_OP  = 6'b111111
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        fetch_req,
   input  logic        PCWre,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] imm,
   input  logic [31:0] rs_data,
   input  logic [31:0] IMemData,
   output logic [31:0] IAddr,
   output logic        RW,
   output logic [31:0] IR,
   output logic [31:0] PC,
   output logic [31:0] PC4,
   output logic        ir_valid,
   output logic        halted
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      VALID,
      HALT
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [31:0] pc_q, pc_nx;
   logic [31:0] ir_q, ir_nx;
   logic        vld, vld_nx;
   logic        hlt, hlt_nx;
   logic [31:0] pc4;
   logic [31:0] tgt;
   logic [31:0] next_pc;
   logic        latch;

   assign pc4   = pc_q + 32'd4;
   assign latch = (state == WAIT) && (cnt == 4'd0);

   always_comb begin
      tgt = pc4;
      case (PCSrc)
         2'b00:   tgt = pc4;
         2'b01:   tgt = pc4 + (imm << 2);
         2'b10:   tgt = {pc4[31:28], ir_q[25:0], 2'b00};
         default: tgt = rs_data;
      endcase
   end

   // Targets are always word aligned, whatever the source supplied.
   assign next_pc = tgt & ~32'd3;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pc_nx    = pc_q;
      ir_nx    = ir_q;
      vld_nx   = vld;
      hlt_nx   = hlt;
      case (state)
         IDLE: begin
            if (fetch_req) begin
               state_nx = WAIT;
               cnt_nx   = LAT_M1;
            end
         end
         WAIT: begin
            if (!latch) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               ir_nx  = IMemData;
               vld_nx = 1'b1;
               if (IMemData[31:26] == HALT_OP) begin
                  state_nx = HALT;
                  hlt_nx   = 1'b1;
               end else begin
                  state_nx = VALID;
               end
            end
         end
         VALID: begin
            if (PCWre) begin
               pc_nx    = next_pc;
               vld_nx   = 1'b0;
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = HALT;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         pc_q  <= RESET_PC;
         ir_q  <= 32'd0;
         vld   <= 1'b0;
         hlt   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         pc_q  <= pc_nx;
         ir_q  <= ir_nx;
         vld   <= vld_nx;
         hlt   <= hlt_nx;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fcnt;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         fcnt <= 32'd0;
      end else if (latch) begin
         fcnt <= fcnt + 32'd1;
      end
   end

   assign fetch_count = fcnt;
`endif

   assign IAddr    = pc_q;
   assign PC       = pc_q;
   assign PC4      = pc4;
   assign RW       = 1'b0;
   assign IR       = ir_q;
   assign ir_valid = vld;
   assign halted   = hlt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: three instances (MEM_LAT 1, 3, 4) share
// one stimulus and are checked each cycle against a cycle-count model.
module tb_instr_fetch_unit;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        Reset;
   logic        fetch_req;
   logic        PCWre;
   logic [1:0]  PCSrc;
   logic [31:0] imm;
   logic [31:0] rs_data;
   logic [31:0] mem [64];

   logic [31:0] iaddr [3];
   logic [31:0] irq   [3];
   logic [31:0] pcq   [3];
   logic [31:0] pc4q  [3];
   logic [31:0] imem  [3];
   logic        rw    [3];
   logic        irv   [3];
   logic        hlt   [3];
`ifdef IF_PERF_CNT_EN
   logic [31:0] fc    [3];
`endif

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign imem[g] = mem[iaddr[g][7:2]];
      instr_fetch_unit #(
         .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .CLK        (CLK),
         .Reset      (Reset),
         .fetch_req  (fetch_req),
         .PCWre      (PCWre),
         .PCSrc      (PCSrc),
         .imm        (imm),
         .rs_data    (rs_data),
         .IMemData   (imem[g]),
         .IAddr      (iaddr[g]),
         .RW         (rw[g]),
         .IR         (irq[g]),
         .PC         (pcq[g]),
         .PC4        (pc4q[g]),
         .ir_valid   (irv[g]),
`ifdef IF_PERF_CNT_EN
         .halted     (hlt[g]),
         .fetch_count(fc[g])
`else
         .halted     (hlt[g])
`endif
      );
   end

   int checks = 0;
   int errors = 0;

   // Reference model: a fetch issued at edge k completes at edge k+lat.
   logic [31:0] m_pc  [3];
   logic [31:0] m_ir  [3];
   logic [31:0] m_cnt [3];
   bit          m_v   [3];
   bit          m_h   [3];
   bit          m_w   [3];
   int          m_due [3];
   int          cyc = 0;

   function automatic int lat(int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 3; i++) begin
         m_pc[i]  = 32'd0;
         m_ir[i]  = 32'd0;
         m_cnt[i] = 32'd0;
         m_v[i]   = 1'b0;
         m_h[i]   = 1'b0;
         m_w[i]   = 1'b0;
         m_due[i] = 0;
      end
   endtask

   task automatic m_edge();
      logic [31:0] p4;
      logic [31:0] t;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         p4 = m_pc[i] + 32'd4;
         if (m_h[i]) begin
         end else if (m_w[i]) begin
            if (cyc == m_due[i]) begin
               m_ir[i]  = mem[m_pc[i][7:2]];
               m_v[i]   = 1'b1;
               m_w[i]   = 1'b0;
               m_cnt[i] = m_cnt[i] + 32'd1;
               if (m_ir[i][31:26] == 6'h3f) m_h[i] = 1'b1;
            end
         end else if (m_v[i]) begin
            if (PCWre) begin
               case (PCSrc)
                  2'd0: t = p4;
                  2'd1: t = p4 + imm * 32'd4;
                  2'd2: t = {p4[31:28], m_ir[i][25:0], 2'b00};
                  default: t = rs_data;
               endcase
               m_pc[i] = {t[31:2], 2'b00};
               m_v[i]  = 1'b0;
            end
         end else if (fetch_req) begin
            m_w[i]   = 1'b1;
            m_due[i] = cyc + lat(i);
         end
      end
   endtask

   task automatic check_all();
      bit bad;
      for (int i = 0; i < 3; i++) begin
         checks++;
         bad = (pcq[i] !== m_pc[i]) || (iaddr[i] !== m_pc[i]) ||
               (pc4q[i] !== m_pc[i] + 32'd4) || (irq[i] !== m_ir[i]) ||
               (irv[i] !== m_v[i]) || (hlt[i] !== m_h[i]) ||
               (rw[i] !== 1'b0);
`ifdef IF_PERF_CNT_EN
         bad = bad || (fc[i] !== m_cnt[i]);
`endif
         if (bad) begin
            errors++;
            $display("FAIL model dut%0d cyc %0d: pc %h/%h iaddr %h pc4 %h ir %h/%h v %b/%b h %b/%b rw %b",
                     i, cyc, pcq[i], m_pc[i], iaddr[i], pc4q[i], irq[i],
                     m_ir[i], irv[i], m_v[i], hlt[i], m_h[i], rw[i]);
         end
      end
   endtask

   task automatic expect32(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      if (Reset) m_reset();
      else m_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      #2 Reset = 1'b1;
      #1 m_reset();
      check_all();
      step();
      Reset = 1'b0;
   endtask

   task automatic fetch(logic [31:0] w);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         for (int i = 0; i < 3; i++)
            expect32($sformatf("lat%0d_e%0d", i, e), 32'(irv[i]),
                     32'(e >= lat(i)));
      end
      for (int i = 0; i < 3; i++) expect32("ir_word", irq[i], w);
   endtask

   task automatic commit(logic [1:0] s, logic [31:0] iv, logic [31:0] rv);
      PCSrc   = s;
      imm     = iv;
      rs_data = rv;
      PCWre   = 1'b1;
      step();
      PCWre   = 1'b0;
   endtask

   task automatic expect_pc(string nm, logic [31:0] exp);
      for (int i = 0; i < 3; i++) expect32(nm, pcq[i], exp);
   endtask

   initial begin
      logic [31:0] w;
      Reset     = 1'b1;
      fetch_req = 1'b0;
      PCWre     = 1'b0;
      PCSrc     = 2'd0;
      imm       = 32'd0;
      rs_data   = 32'd0;
      for (int k = 0; k < 64; k++) mem[k] = 32'h0000_1000;
      mem[0]  = 32'hE000_0002;
      mem[2]  = 32'h0801_0001;
      mem[3]  = 32'hFF62_2000;
      mem[4]  = 32'h1234_5678;
      mem[8]  = 32'h1111_2222;
      mem[63] = 32'h0000_0001;
      m_reset();
      #1 check_all();
      expect32("rst_pc", pcq[0], 32'd0);
      expect32("rst_ir", irq[0], 32'd0);
      expect32("rst_v", 32'(irv[0]), 32'd0);
      expect32("rst_h", 32'(hlt[0]), 32'd0);
      step();
      Reset = 1'b0;

      fetch(32'hE000_0002);
      commit(2'd2, 32'd0, 32'd0);
      expect_pc("jump_pc", 32'h8);
      expect32("jump_v", 32'(irv[0]), 32'd0);

      fetch(32'h0801_0001);
      commit(2'd0, 32'd0, 32'd0);
      expect_pc("seq_pc", 32'hC);

      fetch(32'hFF62_2000);
      expect32("halt_h", 32'(hlt[1]), 32'd1);
      expect32("halt_v", 32'(irv[2]), 32'd1);
      for (int k = 0; k < 10; k++) begin
         fetch_req = 1'b1;
         PCWre     = 1'b1;
         PCSrc     = 2'($urandom);
         rs_data   = $urandom;
         step();
      end
      fetch_req = 1'b0;
      PCWre     = 1'b0;
      expect_pc("halt_pc", 32'hC);
      expect32("halt_ir", irq[0], 32'hFF62_2000);
      do_reset();
      expect_pc("halt_rst_pc", 32'h0);
      expect32("halt_rst_h", 32'(hlt[2]), 32'd0);

      fetch(32'hE000_0002);
      commit(2'd3, 32'd0, 32'h10);
      fetch(32'h1234_5678);
      commit(2'd3, 32'd0, 32'h23);
      expect_pc("rj_pc", 32'h20);
      fetch(32'h1111_2222);
      commit(2'd3, 32'd0, 32'hFFFF_FFFC);
      fetch(32'h0000_0001);
      commit(2'd0, 32'd0, 32'd0);
      expect_pc("wrap_pc", 32'h0);
      fetch(32'hE000_0002);
      commit(2'd3, 32'd0, 32'h10);
      fetch(32'h1234_5678);
      commit(2'd1, 32'hFFFF_FFFE, 32'd0);
      expect_pc("br_pc", 32'hC);

      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      step();
      #3 Reset = 1'b1;
      #1 m_reset();
      check_all();
      expect32("mid_iaddr", iaddr[2], 32'h0);
      expect32("mid_v", 32'(irv[2]), 32'd0);
      expect32("mid_ir", irq[2], 32'd0);
      step();
      Reset = 1'b0;
      repeat (6) step();
      expect32("mid_nolatch", irq[2], 32'd0);

      fetch(32'hE000_0002);
      fetch_req = 1'b1;
      commit(2'd0, 32'd0, 32'd0);
      fetch_req = 1'b0;
      expect_pc("vf_pc", 32'h4);
      repeat (6) step();
      expect32("vf_idle", 32'(irv[1]), 32'd0);
      expect_pc("vf_pc2", 32'h4);

`ifdef IF_PERF_CNT_EN
      do_reset();
      fetch(32'hE000_0002);
      commit(2'd3, 32'd0, 32'h8);
      fetch(32'h0801_0001);
      commit(2'd0, 32'd0, 32'd0);
      fetch(32'hFF62_2000);
      fetch_req = 1'b1;
      repeat (5) step();
      fetch_req = 1'b0;
      for (int i = 0; i < 3; i++) expect32("perf_cnt", fc[i], 32'd3);
`endif

      for (int k = 0; k < 64; k++) begin
         w = $urandom;
         if ($urandom_range(19) != 0) w[31:26] = 6'($urandom_range(62));
         mem[k] = w;
      end
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         fetch_req = 1'($urandom_range(1));
         PCWre     = ($urandom_range(2) == 0);
         PCSrc     = 2'($urandom);
         imm       = 32'($urandom_range(64)) - 32'd32;
         rs_data   = $urandom;
         if ((m_h[0] && m_h[1] && m_h[2]) || $urandom_range(199) == 0)
            do_reset();
         else
            step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
